// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Each bit is decided by a 3-sample majority vote around the middle of the bit period.
module uart_rx #(
    parameter int Data_Width  = 8,
    parameter int Presc_Width = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [Presc_Width-1:0] Prescale,
    output logic [Data_Width-1:0]  P_DATA,
    output logic                   Data_Valid,
    output logic                   Par_Err,
    output logic                   Stp_Err
);

    localparam int Bit_Width = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [Bit_Width-1:0] Last_Bit = Bit_Width'(Data_Width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [Presc_Width-1:0] presc;
    logic [Presc_Width-1:0] half;
    logic [Presc_Width-1:0] edge_cnt;
    logic [Bit_Width-1:0]   bit_cnt;
    logic                   par_en;
    logic                   par_typ;
    logic [2:0]             samples;
    logic [Data_Width-1:0]  data;
    logic                   at_last;
    logic                   at_decide;
    logic                   majority;

    assign half      = presc >> 1;
    assign at_last   = (edge_cnt == presc - Presc_Width'(1));
    assign at_decide = (edge_cnt == half + Presc_Width'(2));
    assign majority  = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

    // Line idles high, so the synchroniser comes out of reset as a 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START: begin
                if (at_decide && majority) next_state = IDLE;
                else if (at_last)          next_state = DATA;
            end
            DATA:    if (at_last && bit_cnt == Last_Bit) next_state = par_en ? PARITY : STOP;
            PARITY:  if (at_last) next_state = STOP;
            STOP:    if (at_decide) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Returning to IDLE at the stop-bit decision leaves about half a bit of
    // slack to catch a start bit that follows immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc      <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            samples    <= '0;
            data       <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;

            if (state == IDLE || next_state == IDLE || at_last) edge_cnt <= '0;
            else                                                edge_cnt <= edge_cnt + Presc_Width'(1);

            if (state != IDLE) begin
                if (edge_cnt == half - Presc_Width'(1)) samples[0] <= rx_s;
                if (edge_cnt == half)                   samples[1] <= rx_s;
                if (edge_cnt == half + Presc_Width'(1)) samples[2] <= rx_s;
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
                if (!rx_s) begin
                    presc   <= Prescale;
                    par_en  <= PAR_EN;
                    par_typ <= PAR_TYP;
                    Par_Err <= 1'b0;
                    Stp_Err <= 1'b0;
                end
            end

            if (state == DATA) begin
                if (at_decide) data[bit_cnt] <= majority;
                if (at_last)   bit_cnt <= (bit_cnt == Last_Bit) ? '0 : bit_cnt + Bit_Width'(1);
            end

            if (state == PARITY && at_decide && (majority != (^data ^ par_typ)))
                Par_Err <= 1'b1;

            if (state == STOP && at_decide) begin
                if (!majority) begin
                    Stp_Err <= 1'b1;
                end else if (!Par_Err) begin
                    P_DATA     <= data;
                    Data_Valid <= 1'b1;
                end
            end
        end
    end

endmodule
